// File: rtl/ram2_responder_if.sv
// Ram2 bus control group between the CPU-side Ram2 controller (master) and the
// block-RAM responder (slave). The bidirectional data line stays a module port.
interface ram2_responder_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] Ram2Addr;
  logic              Ram2EN;
  logic              Ram2OE;
  logic              Ram2WE;

  modport master (
    output Ram2Addr,
    output Ram2EN,
    output Ram2OE,
    output Ram2WE
  );

  modport slave (
    input Ram2Addr,
    input Ram2EN,
    input Ram2OE,
    input Ram2WE
  );
endinterface

// File: rtl/ram2_responder.sv
// Block-RAM stand-in for the board SRAM on the Ram2 bus, with a side preload port
// and sticky contention detection. Define RAM2_RESP_STATS_EN to build access counters.
module ram2_responder #(
  parameter int ADDR_W  = 18,
  parameter int DEPTH_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  ram2_responder_if.slave    bus,
  inout  wire  [15:0]        Ram2Data,
  input  logic               load_en,
  input  logic [DEPTH_W-1:0] load_addr,
  input  logic [15:0]        load_data,
  output logic               load_ready,
  output logic               fault,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    WRITE_LOW = 3'd2,
    COMMIT    = 3'd3,
    FAULT     = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [DEPTH_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]          wr_data_q, wr_data_d;
  logic                 fault_q, fault_d;
  logic [15:0]          rdata_q;
  logic [15:0]          mem [2**DEPTH_W];

  logic                 bus_rd, bus_wr, bus_clash;
  logic                 rd_done, commit;
  logic [DEPTH_W-1:0]   rd_addr;
  logic                 mem_we;
  logic [DEPTH_W-1:0]   mem_waddr;
  logic [15:0]          mem_wdata;

  // Upper address bits alias onto the implemented depth.
  wire unused_addr_hi = ^bus.Ram2Addr[ADDR_W-1:DEPTH_W];

  assign rd_addr   = bus.Ram2Addr[DEPTH_W-1:0];
  assign bus_rd    = !bus.Ram2EN && !bus.Ram2OE &&  bus.Ram2WE;
  assign bus_wr    = !bus.Ram2EN &&  bus.Ram2OE && !bus.Ram2WE;
  assign bus_clash = !bus.Ram2EN && !bus.Ram2OE && !bus.Ram2WE;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_done   = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_rd)         state_d = READ;
        else if (bus_wr)    state_d = WRITE_LOW;
        else if (bus_clash) state_d = FAULT;
      end
      READ: begin
        if (bus.Ram2EN || bus.Ram2OE) begin
          state_d = IDLE;
          rd_done = 1'b1;
        end else if (!bus.Ram2WE) begin
          state_d = FAULT;
        end
      end
      WRITE_LOW: begin
        if (bus.Ram2EN)       state_d = IDLE;
        else if (!bus.Ram2OE) state_d = FAULT;
        else if (bus.Ram2WE)  state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      FAULT: begin
        if (bus.Ram2EN || (bus.Ram2OE && bus.Ram2WE)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Capture only on WE-low samples so the commit never sees rising-edge values.
    if (state_d == WRITE_LOW) begin
      wr_addr_d = rd_addr;
      wr_data_d = Ram2Data;
    end
    fault_d = fault_q || (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fault_q   <= fault_d;
    end
  end

  // Preload shares the single write port; a bus commit always wins it.
  assign load_ready = rst && load_en &&
                      ((state_q == IDLE) || (state_q == READ)) &&
                      !((state_q == IDLE) && !bus.Ram2EN && !bus.Ram2WE);

  assign mem_we    = commit || load_ready;
  assign mem_waddr = commit ? wr_addr_q : load_addr;
  assign mem_wdata = commit ? wr_data_q : load_data;

  // Write-first read port: a same-edge write to the read address is forwarded.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_we && (mem_waddr == rd_addr)) rdata_q <= mem_wdata;
    else                                  rdata_q <= mem[rd_addr];
  end

  assign Ram2Data = (state_q == READ) ? rdata_q : 16'hzzzz;
  assign fault    = fault_q;

`ifdef RAM2_RESP_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q + {15'd0, rd_done};
    wr_count_d = wr_count_q + {15'd0, commit};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  wire unused_rd_done = rd_done;

  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif

endmodule
